// File: rtl/timer_counter_pkg.sv
// timer_counter shared definitions:
// FSM states, register map, CTRL fields.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter bus port:
// word access from the bridge plus irq.
interface timer_counter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (
    output addr, we, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown
// timer with one-shot / auto-reload modes.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  timer_counter_if.slave bus
);

  state_e r_state;
  state_e w_next;

  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic             r_flag;

  logic w_wr_ctrl;
  logic w_wr_pre;
  logic w_more;
  logic w_reload;
  logic w_load;
  logic w_dec;
  logic w_expire;
  logic w_clr_en;
  logic w_clr_flag;

  logic [WIDTH-1:0] w_ctrl_rd;

  assign w_wr_ctrl = bus.we && (bus.addr == OFF_CTRL);
  assign w_wr_pre  = bus.we && (bus.addr == OFF_PRESET);
  assign w_more    = r_count > WIDTH'(1);
  assign w_reload  = r_mode == MODE_RELOAD;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state: idle -> load -> count -> int
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (r_en) w_next = S_LOAD;
      S_LOAD: w_next = S_CNT;
      S_CNT: begin
        if (!r_en)       w_next = S_IDLE;
        else if (!w_more) w_next = S_INT;
      end
      S_INT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // datapath strobes decoded from the state
  always_comb begin
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_expire   = 1'b0;
    w_clr_en   = 1'b0;
    w_clr_flag = 1'b0;
    unique case (r_state)
      S_LOAD: w_load = 1'b1;
      S_CNT: begin
        if (r_en) begin
          w_dec    = w_more;
          w_expire = !w_more;
        end
      end
      S_INT: begin
        w_clr_flag = w_reload;
        w_clr_en   = !w_reload;
      end
      default: ;
    endcase
  end

  // CTRL: bus write beats the one-shot En clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_mode <= 2'd0;
      r_im   <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= bus.wdata[CTRL_EN];
      r_mode <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      r_im   <= bus.wdata[CTRL_IM];
    end else if (w_clr_en) begin
      r_en   <= 1'b0;
    end
  end

  // PRESET: only sampled into count at LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_preset <= '0;
    else if (w_wr_pre) r_preset <= bus.wdata;
  end

  // COUNT: load, decrement, or park at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_count <= '0;
    else if (w_load)   r_count <= r_preset;
    else if (w_dec)    r_count <= r_count - WIDTH'(1);
    else if (w_expire) r_count <= '0;
  end

  // irq flag: any CTRL/PRESET write acks it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_flag <= 1'b0;
    else if (w_wr_ctrl || w_wr_pre) r_flag <= 1'b0;
    else if (w_expire)             r_flag <= 1'b1;
    else if (w_clr_flag)           r_flag <= 1'b0;
  end

  // CTRL readback image, upper bits zero
  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd[CTRL_EN] = r_en;
    w_ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = r_mode;
    w_ctrl_rd[CTRL_IM] = r_im;
  end

  // zero-latency read mux
  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      OFF_CTRL:   bus.rdata = w_ctrl_rd;
      OFF_PRESET: bus.rdata = r_preset;
      OFF_COUNT:  bus.rdata = r_count;
      OFF_RSVD:   bus.rdata = '0;
      default:    bus.rdata = '0;
    endcase
  end

  assign bus.irq = r_flag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed + random bus
// traffic against a phase-based timer model.
module tb_timer_counter;

  localparam int W = 32;
  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PRE  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_RSV  = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  timer_counter_if #(.WIDTH(W)) bus();

  timer_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          n;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  // model: phase 0 idle, 1 load, 2..L+1 counting, L+2 interrupt
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, m_pl;
  int          m_ph;

  function automatic int span();
    return (m_pl == 0) ? 1 : int'(m_pl);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      A_CTRL:  return {28'b0, m_im, m_mode, m_en};
      A_PRE:   return m_preset;
      A_CNT:   return m_count;
      default: return 32'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0; m_pl = 0; m_ph = 0;
  endtask

  task automatic m_step(input logic we, input logic [1:0] a,
                        input logic [31:0] d);
    int   nph;
    logic nen;
    logic nflag;
    nph = m_ph;
    nen = m_en;
    nflag = m_flag;
    if (m_ph == 0) begin
      if (m_en) nph = 1;
    end else if (m_ph == 1) begin
      m_pl = m_preset;
      m_count = m_preset;
      nph = 2;
    end else if (m_ph <= span() + 1) begin
      if (!m_en) nph = 0;
      else if (m_ph < span() + 1) begin
        nph = m_ph + 1;
        m_count = m_pl - 32'(nph - 2);
      end else begin
        m_count = 0;
        nflag = 1;
        nph = span() + 2;
      end
    end else begin
      if (m_mode == 2'd1) nflag = 0;
      else nen = 0;
      nph = 0;
    end
    if (we && a == A_CTRL) begin
      nen = d[0];
      m_mode = d[2:1];
      m_im = d[3];
      nflag = 0;
    end
    if (we && a == A_PRE) begin
      m_preset = d;
      nflag = 0;
    end
    m_en = nen;
    m_flag = nflag;
    m_ph = nph;
  endtask

  task automatic cyc(input logic we, input logic [1:0] a,
                     input logic [31:0] d);
    exp_t e;
    bus.we = we;
    bus.addr = a;
    bus.wdata = d;
    e.rd = m_read(a);
    e.irq = m_flag & m_im;
    e.n = ncyc;
    q.push_back(e);
    @(posedge clk);
    m_step(we, a, d);
    ncyc++;
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (bus.rdata !== mon_e.rd || bus.irq !== mon_e.irq) begin
        failures++;
        $display("FAIL sb cyc=%0d addr=%0d rdata=%h exp=%h irq=%b exp=%b",
                 mon_e.n, bus.addr, bus.rdata, mon_e.rd,
                 bus.irq, mon_e.irq);
      end
    end
  end

  initial begin
    logic [31:0] d;
    int r;
    bus.we = 0;
    bus.addr = 0;
    bus.wdata = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // reset state, idle with no writes
    for (int a = 0; a < 4; a++) rd(2'(a));
    repeat (4) rd(A_CNT);

    // one-shot, P=5, IM set
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    repeat (10) rd(A_CNT);
    rd(A_CTRL);
    rd(A_CTRL);
    wr(A_CTRL, 32'h0);
    rd(A_CTRL);

    // auto-reload, P=3, IM set
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    repeat (28) rd(A_CNT);

    // auto-reload with IM clear, then IM set late
    wr(A_CTRL, 32'h0);
    wr(A_CTRL, 32'h3);
    repeat (14) rd(A_CTRL);
    wr(A_CTRL, 32'hB);
    repeat (4) rd(A_CNT);
    wr(A_CTRL, 32'h0);

    // freeze, preset write and COUNT write mid-count
    wr(A_PRE, 32'd20);
    wr(A_CTRL, 32'h1);
    repeat (12) rd(A_CNT);
    wr(A_CTRL, 32'h0);
    repeat (3) rd(A_CNT);
    wr(A_PRE, 32'd7);
    rd(A_CNT);
    wr(A_CNT, 32'h55);
    rd(A_CNT);
    wr(A_CTRL, 32'h9);
    repeat (12) rd(A_CNT);
    wr(A_CTRL, 32'h0);

    // preset zero behaves like one
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'hB);
    repeat (10) rd(A_CNT);
    wr(A_CTRL, 32'h0);

    // random traffic
    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        d = $urandom_range(0, 15);
        if (r < 5) d[0] = 1'b1;
        wr(A_CTRL, d);
      end else if (r < 14) begin
        wr(A_PRE, $urandom_range(0, 12));
      end else if (r < 16) begin
        d = $urandom;
        wr((r == 14) ? A_CNT : A_RSV, d);
      end else begin
        rd(2'($urandom_range(0, 3)));
      end
    end

    // asynchronous reset mid-count
    wr(A_PRE, 32'd9);
    wr(A_CTRL, 32'h9);
    repeat (6) rd(A_CNT);
    #2 reset = 1'b0;
    bus.we = 1'b0;
    bus.addr = A_CTRL;
    #1;
    chk("rst_irq", {31'b0, bus.irq}, 32'd0);
    chk("rst_ctrl", bus.rdata, 32'd0);
    for (int a = 1; a < 4; a++) begin
      bus.addr = 2'(a);
      #1;
      chk($sformatf("rst_off%0d", a), bus.rdata, 32'd0);
    end
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) rd(A_CNT);
    rd(A_CTRL);
    rd(A_PRE);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer: a bus responder for the CPU core's data-memory port. The system bridge decodes the core's word-address window for this device (0x7F00–0x7F0B or 0x7F10–0x7F1B) and forwards word writes and reads. The timer's interrupt output drives one bit of the core's `HWInt[5:0]` input. The core already rejects sub-word and COUNT-register stores with an address exception, so this block sees only aligned word accesses.

## Interface
Parameters:
- `WIDTH`, 32: data and counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. `reset==0` forces reset state immediately.
- `addr`  in  2  word offset within the device (bridge passes `m_data_addr[3:2]`).
- `we`  in  1  write strobe; valid only when the bridge has selected this device.
- `wdata`  in  WIDTH  write data.
- `rdata`  out  WIDTH  read data, combinational from `addr`.
- `irq`  out  1  interrupt request to `HWInt`.

## Operation
Registers:
- Offset 0 CTRL: bit0 `En`, bits[2:1] `Mode` (0 = one-shot, 1 = auto-reload, 2/3 behave as 0), bit3 `IM` (interrupt mask). Bits[31:4] read 0 and are not stored.
- Offset 1 PRESET: read/write.
- Offset 2 COUNT: read-only; writes are ignored.
- Offset 3: reads 0; writes are ignored.

State machine (`IDLE`, `LOAD`, `CNT`, `INT`):
- `IDLE`: if `En`, go to `LOAD`.
- `LOAD`: `count <= preset`, then go to `CNT`.
- `CNT`:
  - If `!En`, go to `IDLE`; `count` holds its value.
  - Else if `count > 1`, `count <= count-1`.
  - Else `count <= 0`, `irq_flag <= 1`, go to `INT`.
- `INT`:
  - Mode 0: clear `En` and go to `IDLE`; `irq_flag` stays set.
  - Mode 1: clear `irq_flag` and go to `IDLE`; `En` stays set, so the timer reloads.

Interrupt and write rules:
- `irq = irq_flag & IM`.
- `irq_flag` is cleared by any write to CTRL or PRESET.
- A bus write to CTRL in the same cycle the FSM clears `En` wins: the written value is kept.
- A PRESET write during `CNT` does not affect the running count; it takes effect at the next `LOAD`.
- A PRESET value of 0 behaves like 1: the timer passes through `CNT` once, then enters `INT`.

## Timing
Reset values: CTRL=0, PRESET=0, COUNT=0, state `IDLE`, `irq_flag`=0, `irq`=0. `rdata` then reads 0 at every offset.

Counting sequence:
- Write to CTRL with `En=1` at edge E0.
- `LOAD` at E0+1; `count=P`, state `CNT` at E0+2.
- `INT` entered at E0+P+2 for P≥1.
- `irq` is high from E0+P+2.

Mode 1:
- `irq` is a one-cycle pulse.
- Consecutive `INT` entries are P+3 cycles apart.

Bus timing:
- Reads have zero latency (combinational).
- Writes are visible in `rdata` the cycle after the edge.

Reset asserted mid-count: every register and the FSM return to reset values asynchronously, and `irq` drops without waiting for a clock edge.

## Structure
- Shared package `timer_pkg`: state encoding, register offsets (CTRL=0, PRESET=1, COUNT=2), CTRL bit positions, mode constants.
- One flat module; no sub-module is warranted.

## Test plan
- Reset released, no writes: `rdata` reads 0 at offsets 0–3, `irq`=0, state stays `IDLE`.
- PRESET=5, then CTRL=0x9 (En, mode 0, IM):
  - COUNT reads 5,4,3,2,1.
  - `irq` rises 7 cycles after the CTRL write and stays high.
  - CTRL reads 0x8.
  - Writing CTRL=0 drops `irq`.
- PRESET=3, CTRL=0xB (mode 1, IM): `irq` pulses for one cycle every 6 cycles over at least 4 periods.
- Same run with IM=0: the FSM reaches `INT` but `irq` stays 0. Setting IM later does not raise `irq` in mode 1.
- During `CNT` at count=10:
  - Write CTRL=0: COUNT freezes at 9 or 10 and the FSM goes to `IDLE`.
  - A PRESET write mid-count leaves COUNT unchanged until re-enabled.
  - A write to offset 2 is ignored.
- Assert `reset` mid-count between clock edges: `irq` and all registers are 0 immediately. After release, the timer stays `IDLE`.
